// File: rtl/crossing_vote_sequencer.sv
// Purpose: sequences capture triggers to pattern_recognition and debounces its per-frame votes into a stable crossing decision.
// Latency: decision, stripe count and frame count update on the edge ending EVAL, one cycle after detection_valid is sampled.
// Backpressure: none; one frame in flight at a time, and detection_valid is honoured only while waiting for it.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : run the capture/vote loop (sampled in IDLE and EVAL only)
//   capture_trigger          : one-cycle request for a new frame
//   detection_valid, crossing_detected, stripe_count : per-frame result from pattern_recognition
//   crossing_stable, stable_stripe_count, decision_update : debounced decision and its change strobe
//   timeout_err              : sticky, set when a frame result never arrives
//   frame_count              : number of evaluated frames (wraps)
module crossing_vote_sequencer #(
    parameter int CONFIRM_FRAMES = 3,
    parameter int RELEASE_FRAMES = 3,
    parameter int MIN_STRIPES    = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        capture_trigger,
    input  logic        detection_valid,
    input  logic        crossing_detected,
    input  logic [7:0]  stripe_count,
    output logic        crossing_stable,
    output logic [7:0]  stable_stripe_count,
    output logic        decision_update,
    output logic        timeout_err,
    output logic [15:0] frame_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(CONFIRM_FRAMES + 1);
    localparam int NW = $clog2(RELEASE_FRAMES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] P_MAX  = PW'(CONFIRM_FRAMES);
    localparam logic [NW-1:0] N_MAX  = NW'(RELEASE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_EVAL
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            vote_q, vote_d;
    logic [7:0]      stripe_q, stripe_d;
    logic [PW-1:0]   pos_run_q, pos_run_d;
    logic [NW-1:0]   neg_run_q, neg_run_d;
    logic [15:0]     frame_q, frame_d;
    logic            stable_q, stable_d;
    logic [7:0]      ssc_q, ssc_d;
    logic            dupd_q, dupd_d;
    logic            trig_q, trig_d;
    logic            terr_q, terr_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        vote_d    = vote_q;
        stripe_d  = stripe_q;
        pos_run_d = pos_run_q;
        neg_run_d = neg_run_q;
        frame_d   = frame_q;
        stable_d  = stable_q;
        ssc_d     = ssc_q;
        dupd_d    = 1'b0;
        terr_d    = terr_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the terminal timer cycle wins over the timeout.
                if (detection_valid) begin
                    vote_d   = crossing_detected && (int'(stripe_count) >= MIN_STRIPES);
                    stripe_d = stripe_count;
                    state_d  = S_EVAL;
                end else if (timer_q == T_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_TRIG;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_EVAL: begin
                frame_d = frame_q + 16'd1;
                if (vote_q) begin
                    neg_run_d = '0;
                    pos_run_d = (pos_run_q >= P_MAX) ? P_MAX : pos_run_q + 1'b1;
                    if (pos_run_d >= P_MAX) begin
                        stable_d = 1'b1;
                    end
                end else begin
                    pos_run_d = '0;
                    neg_run_d = (neg_run_q >= N_MAX) ? N_MAX : neg_run_q + 1'b1;
                    if (neg_run_d >= N_MAX) begin
                        stable_d = 1'b0;
                    end
                end
                // Stripe count tracks the latest positive vote only while the decision holds.
                if (!stable_d) begin
                    ssc_d = 8'd0;
                end else if (vote_q) begin
                    ssc_d = stripe_q;
                end
                dupd_d  = (stable_d != stable_q);
                state_d = enable ? S_TRIG : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered trigger: high exactly during the TRIG cycle.
        trig_d = (state_d == S_TRIG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            vote_q    <= 1'b0;
            stripe_q  <= 8'd0;
            pos_run_q <= '0;
            neg_run_q <= '0;
            frame_q   <= 16'd0;
            stable_q  <= 1'b0;
            ssc_q     <= 8'd0;
            dupd_q    <= 1'b0;
            trig_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            vote_q    <= vote_d;
            stripe_q  <= stripe_d;
            pos_run_q <= pos_run_d;
            neg_run_q <= neg_run_d;
            frame_q   <= frame_d;
            stable_q  <= stable_d;
            ssc_q     <= ssc_d;
            dupd_q    <= dupd_d;
            trig_q    <= trig_d;
            terr_q    <= terr_d;
        end
    end

    assign capture_trigger     = trig_q;
    assign crossing_stable     = stable_q;
    assign stable_stripe_count = ssc_q;
    assign decision_update     = dupd_q;
    assign timeout_err         = terr_q;
    assign frame_count         = frame_q;

endmodule

// File: tb/tb_crossing_vote_sequencer.sv
// Bench for crossing_vote_sequencer: vote-table sequences, randomized frames against a
// vote-history model, terminal-cycle detection, timeout and mid-frame reset.
module tb_crossing_vote_sequencer;

    localparam int CF = 3;
    localparam int RF = 3;
    localparam int MS = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        capture_trigger;
    logic        detection_valid;
    logic        crossing_detected;
    logic [7:0]  stripe_count;
    logic        crossing_stable;
    logic [7:0]  stable_stripe_count;
    logic        decision_update;
    logic        timeout_err;
    logic [15:0] frame_count;

    crossing_vote_sequencer #(
        .CONFIRM_FRAMES(CF),
        .RELEASE_FRAMES(RF),
        .MIN_STRIPES(MS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .capture_trigger(capture_trigger),
        .detection_valid(detection_valid),
        .crossing_detected(crossing_detected),
        .stripe_count(stripe_count),
        .crossing_stable(crossing_stable),
        .stable_stripe_count(stable_stripe_count),
        .decision_update(decision_update),
        .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: full vote history; decision derived from trailing run lengths.
    bit votes[$];
    bit st_m  = 1'b0;
    int ssc_m = 0;
    int fc_m  = 0;

    typedef struct {
        bit det;
        int sc;
        bit exp_st;
        int exp_ssc;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int trail(input bit v);
        int n = 0;
        for (int i = votes.size() - 1; i >= 0; i--) begin
            if (votes[i] != v) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_frame(input bit vote, input int s);
        votes.push_back(vote);
        if (vote && trail(1'b1) >= CF) st_m = 1'b1;
        else if (!vote && trail(1'b0) >= RF) st_m = 1'b0;
        if (!st_m) ssc_m = 0;
        else if (vote) ssc_m = s;
        fc_m = (fc_m + 1) % 65536;
    endtask

    // One complete frame: wait for trigger, return a result after dly WAIT cycles.
    task automatic do_frame(input bit d, input int s, input int dly, input bit drop_en, input bit chk_period);
        int  waited = 0;
        bit  old_st;
        int  old_fc;
        while (capture_trigger !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        if (capture_trigger !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL trigger_wait: no capture_trigger within %0d cycles", waited);
            return;
        end
        if (chk_period) chk("loop_period_gap", waited, 0);
        tick();                                 // now in WAIT
        if (drop_en) enable = 1'b0;
        repeat (dly) tick();
        detection_valid   = 1'b1;
        crossing_detected = d;
        stripe_count      = 8'(s);
        tick();                                 // now in EVAL
        detection_valid   = 1'b0;
        crossing_detected = 1'($urandom);
        stripe_count      = 8'($urandom);
        old_st = st_m;
        old_fc = fc_m;
        chk("eval_stable_unchanged", crossing_stable, old_st);
        chk("eval_fc_unchanged", frame_count, old_fc);
        chk("eval_update_low", decision_update, 0);
        model_frame(d && (s >= MS), s);
        tick();                                 // edge ending EVAL
        chk("stable", crossing_stable, st_m);
        chk("stable_stripes", stable_stripe_count, ssc_m);
        chk("frame_count", frame_count, fc_m);
        chk("decision_update", decision_update, (st_m != old_st));
        if (drop_en) begin
            repeat (3) begin
                tick();
                chk("idle_no_trigger", capture_trigger, 0);
            end
            enable = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  fc_save;
        bit  prev_held;
        bit  dd;
        bit  de;
        int  ss;
        int  dl;

        tbl[0]  = '{1, 6,   0, 0};
        tbl[1]  = '{1, 6,   0, 0};
        tbl[2]  = '{1, 6,   1, 6};
        tbl[3]  = '{1, 3,   1, 6};
        tbl[4]  = '{1, 3,   1, 6};
        tbl[5]  = '{1, 3,   0, 0};
        tbl[6]  = '{1, 5,   0, 0};
        tbl[7]  = '{1, 5,   0, 0};
        tbl[8]  = '{0, 9,   0, 0};
        tbl[9]  = '{1, 7,   0, 0};
        tbl[10] = '{1, 7,   0, 0};
        tbl[11] = '{1, 8,   1, 8};
        tbl[12] = '{1, 4,   1, 4};
        tbl[13] = '{1, 255, 1, 255};

        rst = 1'b1;
        enable = 1'b0;
        detection_valid = 1'b0;
        crossing_detected = 1'b0;
        stripe_count = 8'd0;
        repeat (3) tick();
        chk("rst_trigger", capture_trigger, 0);
        chk("rst_stable", crossing_stable, 0);
        chk("rst_ssc", stable_stripe_count, 0);
        chk("rst_update", decision_update, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_fc", frame_count, 0);
        rst = 1'b0;

        // Results outside WAIT are ignored.
        detection_valid = 1'b1;
        crossing_detected = 1'b1;
        stripe_count = 8'd9;
        repeat (3) tick();
        detection_valid = 1'b0;
        chk("idle_dv_fc", frame_count, 0);
        chk("idle_dv_trigger", capture_trigger, 0);
        chk("idle_dv_stable", crossing_stable, 0);

        enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            do_frame(tbl[i].det, tbl[i].sc, i % 3, 1'b0, i > 0);
            chk("tbl_stable", crossing_stable, tbl[i].exp_st);
            chk("tbl_ssc", stable_stripe_count, tbl[i].exp_ssc);
            chk("tbl_fc", frame_count, i + 1);
        end

        // Result on the terminal timer cycle is accepted without timeout.
        do_frame(1'b0, 2, TO - 1, 1'b0, 1'b1);
        chk("terminal_no_timeout", timeout_err, 0);

        prev_held = 1'b1;
        for (int i = 0; i < 60; i++) begin
            dd = ($urandom % 4) != 0;
            ss = ($urandom % 10 == 0) ? 255 : int'($urandom_range(0, 9));
            dl = ($urandom % 8 == 0) ? TO - 1 : int'($urandom_range(0, 4));
            de = ($urandom % 8) == 0;
            do_frame(dd, ss, dl, de, prev_held);
            prev_held = !de;
        end
        chk("rand_no_timeout", timeout_err, 0);

        // Timeout: no result for TO WAIT cycles retriggers and sets the sticky flag.
        cnt = 0;
        while (capture_trigger !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        fc_save = fc_m;
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (cnt == TO) chk("timeout_not_early", timeout_err, 0);
        end while (capture_trigger !== 1'b1 && cnt < 40);
        chk("timeout_retrigger_gap", cnt, TO + 1);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_fc", frame_count, fc_save);
        do_frame(1'b1, 5, 0, 1'b0, 1'b1);
        chk("timeout_sticky", timeout_err, 1);

        // Reset mid-WAIT abandons the frame; a late result is ignored.
        cnt = 0;
        while (capture_trigger !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        tick();
        tick();
        rst = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        detection_valid = 1'b1;
        crossing_detected = 1'b1;
        stripe_count = 8'd6;
        tick();
        detection_valid = 1'b0;
        repeat (3) tick();
        chk("rstw_fc", frame_count, 0);
        chk("rstw_stable", crossing_stable, 0);
        chk("rstw_ssc", stable_stripe_count, 0);
        chk("rstw_timeout", timeout_err, 0);
        chk("rstw_trigger", capture_trigger, 0);
        chk("rstw_update", decision_update, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
